uart_rx_frame: RTL and testbench

//  Frame parser directly downstream of the UART receiver. It consumes the byte

---
 rtl/uart_frm_pkg.sv | 30 +++
 rtl/uart_frm_buf.sv | 27 ++
 rtl/uart_rx_frame.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frm_pkg.sv
// Shared types and constants for the UART frame parser.
// States, error causes and the default start-of-frame byte.
package uart_frm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CHK  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_LEN  = 2'd0,
    ERR_CHK  = 2'd1,
    ERR_TMO  = 2'd2,
    ERR_DROP = 2'd3
  } err_t;

  localparam logic [7:0] SOF_DEF = 8'hA5;

  function automatic logic len_ok(
    input logic [7:0] l,
    input int         max_len
  );
    return (l != 8'd0) &&
           (32'(l) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frm_buf.sv
// Payload buffer: register array, one sync write port,
// one async read port, no reset on the storage.
module uart_frm_buf
  import uart_frm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_125m,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_125m) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/uart_rx_frame.sv
// Frame parser behind the UART receiver: SOF, LEN,
// payload, CHK (xor); payload released once CHK passes.
module uart_rx_frame
  import uart_frm_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF         = SOF_DEF,
  parameter int         TIMEOUT_CYC = 1_250_000
) (
  input  logic       clk_125m,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic [7:0] m_data,
  output logic       m_vld,
  output logic       m_last,
  input  logic       m_rdy,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_MAX =
    TW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        state_nx;
  logic [LW-1:0] len;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [7:0]    acc;
  logic [TW-1:0] timer;
  logic [7:0]    rd_data;

  logic in_frm;
  logic tmo_hit;
  logic pay_end;
  logic at_last;
  logic xfer;
  logic buf_we;
  logic ok_nx;
  logic err_nx;
  err_t code_nx;

  assign in_frm  = (state == ST_LEN) ||
                   (state == ST_PAY) ||
                   (state == ST_CHK);
  assign tmo_hit = in_frm && !rx_vld &&
                   (timer == TMO_MAX);
  assign pay_end = (wr_ptr == len - LW'(1));
  assign at_last = (rd_ptr == len - LW'(1));
  assign xfer    = (state == ST_OUT) && m_rdy;
  assign buf_we  = (state == ST_PAY) && rx_vld;

  uart_frm_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_125m (clk_125m),
    .we       (buf_we),
    .wa       (wr_ptr[AW-1:0]),
    .wd       (rx_data),
    .ra       (rd_ptr[AW-1:0]),
    .rd       (rd_data)
  );

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ok_nx    = 1'b0;
    err_nx   = 1'b0;
    code_nx  = ERR_LEN;
    unique case (state)
      ST_IDLE: begin
        if (rx_vld && (rx_data == SOF)) begin
          state_nx = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_vld) begin
          if (len_ok(rx_data, MAX_LEN)) begin
            state_nx = ST_PAY;
          end else begin
            err_nx   = 1'b1;
            code_nx  = ERR_LEN;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_PAY: begin
        if (rx_vld && pay_end) begin
          state_nx = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_vld) begin
          if (rx_data == acc) begin
            ok_nx    = 1'b1;
            state_nx = ST_OUT;
          end else begin
            err_nx   = 1'b1;
            code_nx  = ERR_CHK;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_OUT: begin
        // Bytes arriving while draining are lost.
        if (rx_vld) begin
          err_nx  = 1'b1;
          code_nx = ERR_DROP;
        end
        if (xfer && at_last) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (tmo_hit) begin
      err_nx   = 1'b1;
      code_nx  = ERR_TMO;
      state_nx = ST_IDLE;
    end
  end

  always_comb begin
    m_vld  = (state == ST_OUT);
    m_last = m_vld && at_last;
    m_data = m_vld ? rd_data : 8'h00;
    busy   = (state != ST_IDLE);
  end

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      len      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      acc      <= 8'h00;
      timer    <= '0;
      frm_ok   <= 1'b0;
      frm_err  <= 1'b0;
      err_code <= 2'd0;
    end else begin
      frm_ok  <= ok_nx;
      frm_err <= err_nx;
      if (err_nx) begin
        err_code <= code_nx;
      end
      if (!in_frm || rx_vld || tmo_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
      if ((state == ST_LEN) && rx_vld &&
          len_ok(rx_data, MAX_LEN)) begin
        len    <= rx_data[LW-1:0];
        acc    <= rx_data;
        wr_ptr <= '0;
      end
      if (buf_we) begin
        acc    <= acc ^ rx_data;
        wr_ptr <= wr_ptr + LW'(1);
      end
      if ((state == ST_CHK) && rx_vld) begin
        rd_ptr <= '0;
      end
      if (xfer) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frame-level model
// queues expected payload and status events.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int TMO   = 64;
  localparam int EV_OK = 4;

  logic       clk_125m = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_vld   = 1'b0;
  logic       m_rdy    = 1'b0;
  logic [7:0] m_data;
  logic       m_vld;
  logic       m_last;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic       busy;

  int n_chk    = 0;
  int n_pass   = 0;
  int rdy_mode = 0;

  logic [8:0] exp_data [$];
  int         exp_evt  [$];
  logic [7:0] pay      [$];

  always #4 clk_125m = ~clk_125m;

  uart_rx_frame #(
    .MAX_LEN     (16),
    .SOF         (8'hA5),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_125m (clk_125m),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_vld   (rx_vld),
    .m_data   (m_data),
    .m_vld    (m_vld),
    .m_last   (m_last),
    .m_rdy    (m_rdy),
    .frm_ok   (frm_ok),
    .frm_err  (frm_err),
    .err_code (err_code),
    .busy     (busy)
  );

  function automatic void chk(
    input string nm, input int act, input int exp
  );
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  nm, act, exp);
  endfunction

  function automatic void bad(
    input string nm, input string why
  );
    n_chk++;
    $display("FAIL %s: %s", nm, why);
  endfunction

  // Monitor: compares DUT output against queued model.
  always @(negedge clk_125m) begin
    if (!rst) begin
      if (m_vld) begin
        if (exp_data.size() == 0) begin
          bad("m_vld", "valid with no payload expected");
        end else begin
          chk("m_data", int'(m_data),
              int'(exp_data[0][7:0]));
          chk("m_last", int'(m_last),
              int'(exp_data[0][8]));
          if (m_rdy) void'(exp_data.pop_front());
        end
      end
      if (frm_ok) begin
        if (exp_evt.size() == 0)
          bad("frm_ok", "unexpected ok pulse");
        else
          chk("frm_ok", EV_OK, exp_evt.pop_front());
      end
      if (frm_err) begin
        if (exp_evt.size() == 0)
          bad("frm_err", "unexpected err pulse");
        else
          chk("err_code", int'(err_code),
              exp_evt.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_125m);
      #1;
      case (rdy_mode)
        0:       m_rdy = 1'b1;
        1:       m_rdy = 1'($urandom_range(0, 1));
        2:       m_rdy = 1'b0;
        default: m_rdy = ~m_rdy;
      endcase
    end
  end

  initial begin
    #(8 * 80000);
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    @(posedge clk_125m);
    #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk_125m);
    #1;
    rx_vld = 1'b0;
    repeat (gap) @(posedge clk_125m);
  endtask

  task automatic send_frame(input logic [7:0] flip);
    logic [7:0] x;
    x = 8'(pay.size());
    foreach (pay[i]) x = x ^ pay[i];
    if (flip == 8'h00) begin
      exp_evt.push_back(EV_OK);
      foreach (pay[i])
        exp_data.push_back(
          {(i == pay.size() - 1), pay[i]});
    end else begin
      exp_evt.push_back(1);
    end
    send_byte(8'hA5, $urandom_range(0, 3));
    send_byte(8'(pay.size()), $urandom_range(0, 3));
    foreach (pay[i])
      send_byte(pay[i], $urandom_range(0, 3));
    send_byte(x ^ flip, 0);
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++)
      pay.push_back(8'($urandom));
  endtask

  task automatic garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      while (b == 8'hA5) b = 8'($urandom);
      send_byte(b, $urandom_range(0, 2));
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((exp_data.size() != 0 ||
            exp_evt.size() != 0) && n < 3000) begin
      @(posedge clk_125m);
      n++;
    end
    if (exp_data.size() != 0 || exp_evt.size() != 0) begin
      bad(nm, "expected output never appeared");
      exp_data.delete();
      exp_evt.delete();
    end
    #1;
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  task automatic chk_idle(input string p);
    chk({p, "_m_vld"},    int'(m_vld),    0);
    chk({p, "_m_last"},   int'(m_last),   0);
    chk({p, "_m_data"},   int'(m_data),   0);
    chk({p, "_frm_ok"},   int'(frm_ok),   0);
    chk({p, "_frm_err"},  int'(frm_err),  0);
    chk({p, "_err_code"}, int'(err_code), 0);
    chk({p, "_busy"},     int'(busy),     0);
  endtask

  initial begin
    int n;
    int kind;
    repeat (3) @(posedge clk_125m);
    #1;
    chk_idle("reset");
    rst = 1'b0;

    rdy_mode = 0;
    pay = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00);
    wait_done("t1_good");

    send_frame(8'h07);
    wait_done("t2_badchk");

    exp_evt.push_back(0);
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    exp_evt.push_back(0);
    send_byte(8'hA5, 1);
    send_byte(8'h11, 1);
    wait_done("t3_badlen");

    exp_evt.push_back(2);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    n = 0;
    while (exp_evt.size() != 0 && n < TMO + 50) begin
      @(posedge clk_125m);
      n++;
    end
    chk("t4_tmo_cycles", n, TMO + 1);
    exp_evt.delete();
    rand_pay(3);
    send_frame(8'h00);
    wait_done("t4_after_tmo");

    rdy_mode = 2;
    rand_pay(2);
    send_frame(8'h00);
    repeat (10) @(posedge clk_125m);
    exp_evt.push_back(3);
    send_byte(8'($urandom), 0);
    repeat (40) @(posedge clk_125m);
    rdy_mode = 3;
    wait_done("t5_backpress");

    rdy_mode = 0;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    pay = '{8'h7E};
    send_frame(8'h00);
    wait_done("t6_garbage");
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    #1;
    rst = 1'b1;
    #1;
    chk_idle("t6_in_rst");
    repeat (2) @(posedge clk_125m);
    #1;
    rst = 1'b0;
    @(negedge clk_125m);
    chk_idle("t6_after_rst");

    for (int it = 0; it < 30; it++) begin
      rdy_mode = $urandom_range(0, 1);
      garbage($urandom_range(0, 2));
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        rand_pay($urandom_range(1, 16));
        send_frame(8'h00);
      end else if (kind == 2) begin
        rand_pay($urandom_range(1, 16));
        send_frame(8'($urandom_range(1, 255)));
      end else begin
        exp_evt.push_back(0);
        send_byte(8'hA5, $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0)
          send_byte(8'h00, 0);
        else
          send_byte(8'($urandom_range(17, 255)), 0);
      end
      wait_done("rand");
    end

    repeat (5) @(posedge clk_125m);
    #1;
    chk("end_m_vld", int'(m_vld), 0);
    chk("end_data_q", exp_data.size(), 0);
    chk("end_evt_q", exp_evt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
